// File: rtl/p3_5_observer_if.sv
// Receive-side link bundle for the p3_5 observer: {y,z} symbol in, decoded result out.
// master = symbol source / result consumer, slave = the observer itself.
interface p3_5_observer_if #(
    parameter int CNT_W = 8
) ();
    logic             in_valid;
    logic             y;
    logic             z;
    logic             out_valid;
    logic             x_out;
    logic             x_known;
    logic             err;
    logic [2:0]       state_set;
    logic             locked;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, y, z,
        input  out_valid, x_out, x_known, err, state_set, locked, err_cnt
    );

    modport slave (
        input  in_valid, y, z,
        output out_valid, x_out, x_known, err, state_set, locked, err_cnt
    );
endinterface

// File: rtl/p3_5_observer.sv
// Belief-set observer for the 3-state p3_5 Mealy encoder: recovers x from {y,z}, flags bad symbols.
// Optional saturating error counter is built when P3_5_OBS_STATS_EN is defined.
module p3_5_observer #(
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    p3_5_observer_if.slave  obs
);
    // state_set bit positions: bit0=A, bit1=B, bit2=C
    localparam logic [2:0] S_A   = 3'b001;
    localparam logic [2:0] S_C   = 3'b100;
    localparam logic [2:0] S_ALL = 3'b111;

    logic [2:0] state_set_q, state_set_d;
    logic       out_valid_q, out_valid_d;
    logic       x_out_q,     x_out_d;
    logic       x_known_q,   x_known_d;
    logic       err_q,       err_d;
    logic       sym_err;

    always_comb begin
        state_set_d = state_set_q;
        out_valid_d = obs.in_valid;
        x_out_d     = x_out_q;
        x_known_d   = x_known_q;
        err_d       = err_q;
        sym_err     = 1'b0;
        if (obs.in_valid) begin
            err_d = 1'b0;
            unique case ({obs.y, obs.z})
                2'b11: begin
                    if (state_set_q[0]) begin
                        state_set_d = S_C;
                        x_out_d     = 1'b1;
                        x_known_d   = 1'b1;
                    end else begin
                        sym_err = 1'b1;
                    end
                end
                2'b10: begin
                    if (state_set_q[2]) begin
                        state_set_d = S_A;
                        x_out_d     = 1'b0;
                        x_known_d   = 1'b1;
                    end else begin
                        sym_err = 1'b1;
                    end
                end
                2'b01: begin
                    // A->B (x=0), B->B|C (x ambiguous), C->C (x=1)
                    state_set_d = {state_set_q[1] | state_set_q[2],
                                   state_set_q[0] | state_set_q[1],
                                   1'b0};
                    x_known_d   = (state_set_q == S_A) || (state_set_q == S_C);
                    x_out_d     = (state_set_q == S_C);
                end
                default: sym_err = 1'b1;
            endcase
            if (sym_err) begin
                state_set_d = S_ALL;
                x_out_d     = 1'b0;
                x_known_d   = 1'b0;
                err_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_set_q <= S_A;
            out_valid_q <= 1'b0;
            x_out_q     <= 1'b0;
            x_known_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_set_q <= state_set_d;
            out_valid_q <= out_valid_d;
            x_out_q     <= x_out_d;
            x_known_q   <= x_known_d;
            err_q       <= err_d;
        end
    end

    assign obs.out_valid = out_valid_q;
    assign obs.x_out     = x_out_q;
    assign obs.x_known   = x_known_q;
    // err holds internally across gaps but is only shown alongside out_valid
    assign obs.err       = err_q & out_valid_q;
    assign obs.state_set = state_set_q;
    assign obs.locked    = $onehot(state_set_q);

`ifdef P3_5_OBS_STATS_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (obs.in_valid && sym_err && (err_cnt_q != {CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign obs.err_cnt = err_cnt_q;
`else
    assign obs.err_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_p3_5_observer.sv
// Scoreboard bench for p3_5_observer: directed symbols push expectations, a negedge monitor checks them.
module tb_p3_5_observer;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic             x_out;
        logic             x_known;
        logic             err;
        logic [2:0]       state_set;
        logic             locked;
        logic [CNT_W-1:0] err_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    p3_5_observer_if #(.CNT_W(CNT_W)) bus ();
    p3_5_observer #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .obs(bus));

    exp_t q[$];
    int checks = 0;
    int passes = 0;
    int ecnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got %0h want %0h", name, act, want);
    endtask

    // Monitor: every out_valid cycle must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("x_out",     32'(bus.x_out),     32'(e.x_out));
                chk("x_known",   32'(bus.x_known),   32'(e.x_known));
                chk("err",       32'(bus.err),       32'(e.err));
                chk("state_set", 32'(bus.state_set), 32'(e.state_set));
                chk("locked",    32'(bus.locked),    32'(e.locked));
                chk("err_cnt",   32'(bus.err_cnt),   32'(e.err_cnt));
            end
        end
    end

    task automatic sym(input logic y, input logic z, input logic x, input logic k,
                       input logic e, input logic [2:0] s, input logic l);
        exp_t ex;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.y = y;
        bus.z = z;
`ifdef P3_5_OBS_STATS_EN
        if (e) ecnt++;
`endif
        ex.x_out = x; ex.x_known = k; ex.err = e;
        ex.state_set = s; ex.locked = l; ex.err_cnt = CNT_W'(ecnt);
        q.push_back(ex);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.y = 1'b0;
        bus.z = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state_set"}, 32'(bus.state_set), 32'd1);
        chk({tag, "_locked"},    32'(bus.locked),    32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_x_out"},     32'(bus.x_out),     32'd0);
        chk({tag, "_x_known"},   32'(bus.x_known),   32'd0);
        chk({tag, "_err"},       32'(bus.err),       32'd0);
        chk({tag, "_err_cnt"},   32'(bus.err_cnt),   32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.y = 1'b0;
        bus.z = 1'b0;
        #12;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        //   y  z   x  k  e  S       L
        sym(1, 1,  1, 1, 0, 3'b100, 1);
        sym(1, 0,  0, 1, 0, 3'b001, 1);
        sym(0, 1,  0, 1, 0, 3'b010, 1);
        sym(0, 1,  0, 0, 0, 3'b110, 0);
        sym(0, 1,  0, 0, 0, 3'b110, 0);
        sym(1, 0,  0, 1, 0, 3'b001, 1);
        sym(0, 1,  0, 1, 0, 3'b010, 1);
        sym(1, 0,  0, 0, 1, 3'b111, 0);   // C not possible from {B}
        sym(1, 1,  1, 1, 0, 3'b100, 1);
        sym(0, 1,  1, 1, 0, 3'b100, 1);
        sym(0, 0,  0, 0, 1, 3'b111, 0);
        sym(0, 0,  0, 0, 1, 3'b111, 0);
        sym(0, 0,  0, 0, 1, 3'b111, 0);
        sym(0, 1,  0, 0, 0, 3'b110, 0);
        sym(1, 1,  0, 0, 1, 3'b111, 0);   // A not in {B,C}
        sym(1, 1,  1, 1, 0, 3'b100, 1);

        // gap: nothing presented, S held
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("gap_out_valid", 32'(bus.out_valid), 32'd0);
            chk("gap_state_set", 32'(bus.state_set), 32'b100);
        end

        sym(1, 0,  0, 1, 0, 3'b001, 1);
        sym(0, 1,  0, 1, 0, 3'b010, 1);
        idle();
        @(negedge clk);

        // asynchronous reset between edges
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        ecnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        sym(0, 1,  0, 1, 0, 3'b010, 1);   // resumes from {A}
        idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
